// File: rtl/data_memory.sv
// Line-wide data memory with fixed-latency request/ack handshake and one outstanding transaction.
// Optional DATA_MEMORY_RANGE_CHECK_EN: requests with addr_i above the 16 KB window are acked but return zeros and do not write.
module data_memory #(
  parameter int unsigned MEM_DEPTH  = 512,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned LATENCY    = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           addr_i,
  input  logic [LINE_WIDTH-1:0] data_i,
  input  logic                  enable_i,
  input  logic                  write_i,
  output logic                  ack_o,
  output logic [LINE_WIDTH-1:0] data_o
);

  localparam int unsigned IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_RAW = $clog2(LATENCY + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 4) ? 4 : CNT_RAW;
  localparam int unsigned HI_LSB  = 5 + IDX_W;

  if (LATENCY < 2) begin : g_bad_latency
    $error("data_memory: LATENCY must be 2 or more");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  oor_q, oor_d;
  logic                  ack_d;
  logic [LINE_WIDTH-1:0] rdata_d;
  logic                  mem_we;
  logic                  req_oor;

  logic [LINE_WIDTH-1:0] memory [MEM_DEPTH];

  // Byte offset within a line never selects anything.
  logic unused_offset;
  assign unused_offset = ^addr_i[4:0];

`ifdef DATA_MEMORY_RANGE_CHECK_EN
  assign req_oor = |addr_i[31:HI_LSB];
`else
  logic unused_high;
  assign unused_high = ^addr_i[31:HI_LSB];
  assign req_oor     = 1'b0;
`endif

  // Next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    write_d = write_q;
    oor_d   = oor_q;
    ack_d   = 1'b0;
    rdata_d = '0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = BUSY;
          cnt_d   = '0;
          idx_d   = addr_i[5 +: IDX_W];
          wdata_d = data_i;
          write_d = write_i;
          oor_d   = req_oor;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // Read one edge before the write so data_o shows the pre-write line.
        if (cnt_q == CNT_W'(LATENCY - 2)) begin
          ack_d   = 1'b1;
          rdata_d = oor_q ? '0 : memory[idx_q];
        end
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          state_d = IDLE;
          mem_we  = write_q & ~oor_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      oor_q   <= 1'b0;
      ack_o   <= 1'b0;
      data_o  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      oor_q   <= oor_d;
      ack_o   <= ack_d;
      data_o  <= rdata_d;
    end
  end

  // Storage has no reset; a reset edge also blocks the commit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) begin
      memory[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Randomized bench for data_memory against a line-array reference model with per-cycle ack/data checks.
module tb_data_memory;

  localparam int unsigned LW    = 256;
  localparam int unsigned LAT   = 10;
  localparam int unsigned DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr;
  logic [LW-1:0] din;
  logic          en;
  logic          wr;
  logic          ack;
  logic [LW-1:0] dout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [LW-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  data_memory #(
    .MEM_DEPTH (DEPTH),
    .LINE_WIDTH(LW),
    .LATENCY   (LAT)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .addr_i  (addr),
    .data_i  (din),
    .enable_i(en),
    .write_i (wr),
    .ack_o   (ack),
    .data_o  (dout)
  );

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int w = 0; w < LW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit is_oor(input logic [31:0] a);
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    return a[31:14] != 18'd0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic junk_inputs();
    addr = $urandom;
    din  = rand_line();
    wr   = 1'($urandom_range(0, 1));
  endtask

  // One full transaction: must be called at a negedge; returns at the negedge after completion.
  task automatic run_txn(input logic [31:0] a, input logic [LW-1:0] d, input bit w, input bit hold,
                         input string tag);
    int            ix;
    bit            oor;
    logic [LW-1:0] exp_rd;
    ix     = int'(a[13:5]);
    oor    = is_oor(a);
    exp_rd = oor ? '0 : ref_mem[ix];
    addr   = a;
    din    = d;
    wr     = w;
    en     = 1'b1;
    for (int k = 0; k <= int'(LAT); k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) begin
        junk_inputs();
        en = hold;
      end
      if (k == int'(LAT) - 1) begin
        check({tag, "/ack"}, LW'(ack), LW'(1));
        check({tag, "/rdata"}, dout, exp_rd);
        if (w) check({tag, "/mem_prewrite"}, dut.memory[ix], ref_mem[ix]);
      end else begin
        check({tag, "/ack_idle"}, LW'(ack), LW'(0));
        check({tag, "/data_idle"}, dout, '0);
      end
      if (k == int'(LAT)) begin
        if (w && !oor) ref_mem[ix] = d;
        check({tag, "/mem_post"}, dut.memory[ix], ref_mem[ix]);
      end
    end
  endtask

  initial begin
    logic [LW-1:0] pat0, pat32, pat16, ecfa;
    rst  = 1'b1;
    en   = 1'b0;
    wr   = 1'b0;
    addr = '0;
    din  = '0;

    for (int g = 0; g < 16; g++) begin
      pat0[g*16 +: 16]  = 16'((15 - g) * 4369);
      pat32[g*16 +: 16] = (g == 15) ? 16'h0000 : {4'(15 - g), 8'h00, 4'(15 - g)};
      ecfa[g*16 +: 16]  = 16'hECFA;
    end
    pat16 = {2{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}};
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = rand_line();
    ref_mem[0]  = pat0;
    ref_mem[16] = pat16;
    ref_mem[32] = pat32;
    for (int i = 0; i < int'(DEPTH); i++) dut.memory[i] = ref_mem[i];

    // Reset wins over a pending request.
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/ack", LW'(ack), LW'(0));
    check("reset/data", dout, '0);
    rst = 1'b0;
    en  = 1'b0;

    run_txn(32'h0000_0000, rand_line(), 1'b0, 1'b0, "rd_line0");
    check("rd_line0/model", ref_mem[0], pat0);

    run_txn(32'h0000_0220, ecfa, 1'b1, 1'b0, "wr_line17");
    run_txn(32'h0000_0220, rand_line(), 1'b0, 1'b0, "rd_line17");
    check("wr_line17/mem", dut.memory[17], ecfa);

    // Abort a write with reset at edge E+5.
    addr = 32'h0000_0400;
    din  = rand_line();
    wr   = 1'b1;
    en   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) begin
        junk_inputs();
        en = 1'b0;
      end
      check("abort/ack_pre", LW'(ack), LW'(0));
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort/ack_rst", LW'(ack), LW'(0));
    check("abort/data_rst", dout, '0);
    for (int k = 0; k < int'(LAT); k++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort/no_ack", LW'(ack), LW'(0));
    end
    check("abort/mem32", dut.memory[32], pat32);
    run_txn(32'h0000_0400, rand_line(), 1'b0, 1'b0, "abort/rd_after");

    // Back-to-back reads with enable held.
    run_txn(32'h0000_0000, rand_line(), 1'b0, 1'b1, "b2b_first");
    run_txn(32'h0000_0200, rand_line(), 1'b0, 1'b0, "b2b_second");
    check("b2b/line16", ref_mem[16], pat16);

    // Above the 16 KB window: alias to line 0, or rejected with range check.
    run_txn(32'h0001_0000, rand_line(), 1'b1, 1'b0, "high_wr");
    run_txn(32'h0000_0000, rand_line(), 1'b0, 1'b0, "high_rd0");

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      bit          hold;
      a    = ($urandom_range(0, 1) == 1) ? 32'($urandom) : (32'($urandom) & 32'h0000_3FFF);
      hold = (t != 39) && ($urandom_range(0, 2) == 0);
      run_txn(a, rand_line(), 1'($urandom_range(0, 1)), hold, $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
